bram_log_ctrl: RTL and testbench
================================

// Module: bram_log_ctrl
// PURPOSE
//   Sequences the data-logging BRAM behind the processor command interface (RUN_MEM / READ_MEM /
//   ADDR_MEM / IS_MEM_FULL). On a run request it fills the BRAM with one sample per valid strobe
//   from address 0 up to the last address, then flags memory full. After that it serves
//   processor reads at a requested address. Owns the single BRAM port; sits between the command
//   register file and the BRAM.
// PARAMETERS
//   BRAM_ADDR_WIDTH  15  BRAM address width; depth = 2**BRAM_ADDR_WIDTH words
//   BRAM_DATA_WIDTH  16  BRAM word width = logged sample width
// PORTS
//   clk           in   1                clock
//   i_rst         in   1                asynchronous reset, active high
//   i_run_log     in   1                run request level from register file; rising edge starts logging
//   i_read_log    in   1                read enable level from register file
//   i_addr_log    in   BRAM_ADDR_WIDTH  processor read address
//   i_data        in   BRAM_DATA_WIDTH  sample to log
//   i_data_valid  in   1                sample strobe, one word per high cycle
//   o_bram_en     out  1                BRAM port enable
//   o_bram_we     out  1                BRAM write enable
//   o_bram_addr   out  BRAM_ADDR_WIDTH  BRAM address
//   o_bram_wdata  out  BRAM_DATA_WIDTH  BRAM write data
//   i_bram_rdata  in   BRAM_DATA_WIDTH  BRAM read data, 1-cycle latency after en/addr
//   o_data_log    out  BRAM_DATA_WIDTH  registered read data to register file
//   o_data_vld    out  1                one-cycle pulse when o_data_log updates
//   o_mem_full    out  1                memory full flag (IS_MEM_FULL readback)
//   o_busy        out  1                high while logging
// BEHAVIOUR
//   - Reset (async, any state): state=IDLE; wr counter=0; all outputs 0; run edge detector cleared
//     (register holds 0, so a run level held high through reset release starts logging).
//   - All BRAM port outputs registered; o_data_log/o_data_vld registered.
//   - Run edge: run_q <= i_run_log; start = i_run_log & ~run_q.
//   - States: IDLE, LOG, FULL.
//     IDLE: start -> LOG, wr counter=0, o_mem_full=0.
//     LOG: o_busy=1. Each cycle with i_data_valid: en=1, we=1, addr=counter, wdata=i_data,
//       counter+1. Write at addr 2**AW-1 -> FULL next cycle with o_mem_full=1; counter wraps to 0
//       (no write beyond last address). start in LOG -> restart: counter=0, that cycle's sample
//       (if valid) is written at addr 0. i_read_log ignored in LOG.
//     FULL: o_mem_full=1 held; start -> LOG, o_mem_full=0 same cycle as entry, counter=0.
//   - Read (IDLE or FULL, i_read_log=1): en=1, we=0, addr=i_addr_log at cycle T+1 (T = inputs
//     sampled); i_bram_rdata valid T+2; o_data_log and o_data_vld=1 at T+3. Continuous read while
//     i_read_log high (one result per cycle, address tracking i_addr_log). o_data_log holds last
//     value when no read.
//   - Start and read in the same cycle: start wins; read dropped.
//   - Counter is exactly BRAM_ADDR_WIDTH bits, unsigned; no sample lost or duplicated in LOG.
//   - o_bram_en=0 and o_bram_we=0 in any cycle with no write and no read.
// TESTING (bench with BRAM_ADDR_WIDTH=4, behavioral 1-cycle BRAM)
//   - Reset check: i_rst=1 mid-LOG after 5 writes -> all outputs 0 next edge, state IDLE;
//     new start writes from addr 0.
//   - Fill: start, i_data=0x100+n with valid every cycle -> 16 writes to addr 0..15,
//     o_mem_full=1 one cycle after the write at addr 15, o_busy=0 then.
//   - Gapped valid: valid every 3rd cycle -> still 16 writes, addresses contiguous, full after 16th.
//   - Readback: after fill, i_read_log=1 with i_addr_log=7 -> o_data_log=0x107 and
//     o_data_vld=1 three cycles later; sweep addr 0..15 back-to-back -> 0x100..0x10F in order.
//   - Restart: start in LOG after 9 writes -> next write at addr 0, o_mem_full stays 0
//     until 16 further writes.
//   - Conflicts: i_read_log=1 during LOG -> no read, o_data_vld=0, we continues;
//     start+read same cycle in FULL -> LOG entered, o_mem_full=0, no o_data_vld pulse.

Source files
------------

// File: rtl/bram_log_ctrl.sv
// bram_log_ctrl: fills a single-port logging BRAM with valid samples on a run edge, then serves processor reads
//
// Ports:
//   clk, i_rst                  clock, asynchronous active-high reset
//   i_run_log                   run request level; a rising edge starts (or restarts) logging
//   i_read_log, i_addr_log      processor read enable level and read address
//   i_data, i_data_valid        sample to log and its one-word-per-cycle strobe
//   o_bram_en/we/addr/wdata     registered BRAM port drive
//   i_bram_rdata                BRAM read data, one cycle after en/addr
//   o_data_log, o_data_vld      registered read result and its one-cycle update pulse
//   o_mem_full, o_busy          memory full flag and logging-in-progress flag
module bram_log_ctrl #(
    parameter int BRAM_ADDR_WIDTH = 15,
    parameter int BRAM_DATA_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       i_rst,
    input  logic                       i_run_log,
    input  logic                       i_read_log,
    input  logic [BRAM_ADDR_WIDTH-1:0] i_addr_log,
    input  logic [BRAM_DATA_WIDTH-1:0] i_data,
    input  logic                       i_data_valid,
    output logic                       o_bram_en,
    output logic                       o_bram_we,
    output logic [BRAM_ADDR_WIDTH-1:0] o_bram_addr,
    output logic [BRAM_DATA_WIDTH-1:0] o_bram_wdata,
    input  logic [BRAM_DATA_WIDTH-1:0] i_bram_rdata,
    output logic [BRAM_DATA_WIDTH-1:0] o_data_log,
    output logic                       o_data_vld,
    output logic                       o_mem_full,
    output logic                       o_busy
);
    typedef enum logic [1:0] {IDLE, LOG, FULL} state_t;
    state_t state, state_n;
    logic [BRAM_ADDR_WIDTH-1:0] cnt, cnt_n, wa, addr_n;
    logic [BRAM_DATA_WIDTH-1:0] wdata_n;
    logic run_q, start, en_n, we_n, rd_n, rd_p1, rd_p2;

    assign start      = i_run_log & ~run_q;
    assign wa         = start ? '0 : cnt;
    assign o_busy     = state == LOG;
    assign o_mem_full = state == FULL;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        en_n    = 1'b0;
        we_n    = 1'b0;
        rd_n    = 1'b0;
        addr_n  = o_bram_addr;
        wdata_n = o_bram_wdata;
        case (state)
            LOG: begin
                // a restart rewinds to address 0 and still keeps this cycle's sample
                cnt_n = wa;
                if (i_data_valid) begin
                    en_n    = 1'b1;
                    we_n    = 1'b1;
                    addr_n  = wa;
                    wdata_n = i_data;
                    cnt_n   = wa + 1'b1;
                    if (&wa) state_n = FULL;
                end
            end
            default: begin
                if (start) begin
                    state_n = LOG;
                    cnt_n   = '0;
                end else if (i_read_log) begin
                    en_n   = 1'b1;
                    addr_n = i_addr_log;
                    rd_n   = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= IDLE;
            cnt          <= '0;
            run_q        <= 1'b0;
            o_bram_en    <= 1'b0;
            o_bram_we    <= 1'b0;
            o_bram_addr  <= '0;
            o_bram_wdata <= '0;
            rd_p1        <= 1'b0;
            rd_p2        <= 1'b0;
            o_data_vld   <= 1'b0;
            o_data_log   <= '0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            run_q        <= i_run_log;
            o_bram_en    <= en_n;
            o_bram_we    <= we_n;
            o_bram_addr  <= addr_n;
            o_bram_wdata <= wdata_n;
            // rd_p1: read on the BRAM port, rd_p2: BRAM data now valid
            rd_p1        <= rd_n;
            rd_p2        <= rd_p1;
            o_data_vld   <= rd_p2;
            if (rd_p2) o_data_log <= i_bram_rdata;
        end
    end
endmodule

// File: tb/tb_bram_log_ctrl.sv
// tb_bram_log_ctrl: directed and randomized checks of bram_log_ctrl against a sample-index reference model
module tb_bram_log_ctrl;
    localparam int AW = 4;
    localparam int DW = 16;
    localparam int D  = 1 << AW;

    logic clk = 1'b0, i_rst = 1'b1;
    logic i_run_log = 1'b0, i_read_log = 1'b0, i_data_valid = 1'b0;
    logic [AW-1:0] i_addr_log = '0;
    logic [DW-1:0] i_data = '0, i_bram_rdata = '0;
    logic o_bram_en, o_bram_we, o_data_vld, o_mem_full, o_busy;
    logic [AW-1:0] o_bram_addr;
    logic [DW-1:0] o_bram_wdata, o_data_log;

    bram_log_ctrl #(.BRAM_ADDR_WIDTH(AW), .BRAM_DATA_WIDTH(DW)) dut (
        .clk(clk), .i_rst(i_rst), .i_run_log(i_run_log), .i_read_log(i_read_log),
        .i_addr_log(i_addr_log), .i_data(i_data), .i_data_valid(i_data_valid),
        .o_bram_en(o_bram_en), .o_bram_we(o_bram_we), .o_bram_addr(o_bram_addr),
        .o_bram_wdata(o_bram_wdata), .i_bram_rdata(i_bram_rdata), .o_data_log(o_data_log),
        .o_data_vld(o_data_vld), .o_mem_full(o_mem_full), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [D];
    always @(posedge clk)
        if (o_bram_en) begin
            if (o_bram_we) mem[o_bram_addr] <= o_bram_wdata;
            else i_bram_rdata <= mem[o_bram_addr];
        end

    // reference model: sample index since start, logging/full flags, memory image, read pipeline
    bit m_log, m_full, m_prev;
    int m_idx;
    logic [DW-1:0] ref_mem [D];
    bit pv [3];
    logic [DW-1:0] pd [3];
    logic [DW-1:0] exp_log;
    int tests = 0, fails = 0;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_en"}, o_bram_en, 0);
        chk({tag, "_we"}, o_bram_we, 0);
        chk({tag, "_addr"}, o_bram_addr, 0);
        chk({tag, "_wdata"}, o_bram_wdata, 0);
        chk({tag, "_dlog"}, o_data_log, 0);
        chk({tag, "_vld"}, o_data_vld, 0);
        chk({tag, "_full"}, o_mem_full, 0);
        chk({tag, "_busy"}, o_busy, 0);
    endtask

    task automatic model_reset();
        m_log = 0; m_full = 0; m_prev = 0; m_idx = 0; exp_log = '0;
        for (int i = 0; i < 3; i++) begin pv[i] = 0; pd[i] = '0; end
    endtask

    task automatic step(bit run, bit rd, logic [AW-1:0] a, logic [DW-1:0] d, bit v);
        bit st, wr, rq;
        logic [AW-1:0] wa;
        i_run_log = run; i_read_log = rd; i_addr_log = a; i_data = d; i_data_valid = v;
        st = run && !m_prev;
        m_prev = run;
        wr = 0; rq = 0; wa = '0;
        if (st) begin
            wr = m_log && v;
            m_log = 1; m_full = 0; m_idx = 0;
        end else if (m_log) begin
            wr = v;
            wa = m_idx[AW-1:0];
        end else if (rd) begin
            rq = 1;
            wa = a;
        end
        if (wr) begin
            ref_mem[wa] = d;
            m_idx++;
            if (m_idx == D) begin m_log = 0; m_full = 1; end
        end
        pv[2] = pv[1]; pd[2] = pd[1];
        pv[1] = pv[0]; pd[1] = pd[0];
        pv[0] = rq;    pd[0] = rq ? ref_mem[a] : '0;
        @(posedge clk); #1;
        if (pv[2]) exp_log = pd[2];
        chk("en", o_bram_en, wr | rq);
        chk("we", o_bram_we, wr);
        chk("busy", o_busy, m_log);
        chk("full", o_mem_full, m_full);
        chk("vld", o_data_vld, pv[2]);
        chk("dlog", o_data_log, exp_log);
        if (wr | rq) chk("addr", o_bram_addr, wa);
        if (wr) chk("wdata", o_bram_wdata, d);
    endtask

    initial begin
        for (int i = 0; i < D; i++) begin mem[i] = '0; ref_mem[i] = '0; end
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk_zero("rst_init");
        i_rst = 1'b0;

        // five writes, then an asynchronous reset mid-log with run held high
        step(1, 0, '0, '0, 0);
        for (int n = 0; n < 5; n++) step(1, 0, '0, DW'($urandom), 1);
        #2 i_rst = 1'b1;
        #1;
        chk_zero("rst_mid");
        model_reset();
        repeat (2) @(posedge clk);
        #1 i_rst = 1'b0;

        // run still high after release: new start, then a full contiguous fill
        step(1, 0, '0, '0, 0);
        for (int n = 0; n < D; n++) step(1, 0, '0, DW'(16'h100 + n), 1);
        step(0, 0, '0, '0, 0);

        // single read then back-to-back sweep
        step(0, 1, AW'(7), '0, 0);
        step(0, 0, '0, '0, 0);
        step(0, 0, '0, '0, 0);
        chk("read7", o_data_log, 16'h107);
        for (int n = 0; n < D; n++) step(0, 1, AW'(n), '0, 0);
        for (int n = 0; n < 3; n++) step(0, 0, '0, '0, 0);
        chk("sweep_last", o_data_log, 16'h10F);

        // gapped valid with reads attempted during logging
        step(1, 0, '0, '0, 0);
        for (int n = 0; n < 80 && m_log; n++)
            step(1, 1'($urandom), AW'($urandom), DW'($urandom), n % 3 == 2);
        chk("gap_full", o_mem_full, 1);

        // restart after nine writes (plus one with run low), then refill
        step(0, 0, '0, '0, 0);
        step(1, 0, '0, '0, 0);
        for (int n = 0; n < 9; n++) step(1, 0, '0, DW'($urandom), 1);
        step(0, 0, '0, DW'($urandom), 1);
        step(1, 0, '0, DW'($urandom), 1);
        chk("restart_addr", o_bram_addr, 0);
        for (int n = 0; n < 100 && m_log; n++)
            step(1, 1'($urandom), AW'($urandom), DW'($urandom), 1'($urandom));

        // start and read in the same cycle from FULL
        step(0, 0, '0, '0, 0);
        step(1, 1, AW'(5), '0, 0);
        for (int n = 0; n < 3; n++) step(1, 0, '0, '0, 0);
        for (int n = 0; n < 40 && m_log; n++) step(1, 0, '0, DW'($urandom), 1);

        // free-running random traffic
        for (int n = 0; n < 400; n++)
            step(($urandom_range(0, 15) == 0) ? !i_run_log : i_run_log,
                 1'($urandom), AW'($urandom), DW'($urandom), 1'($urandom));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
